inbuf_sched: RTL and testbench
==============================

# inbuf_sched

Frame-level sequencer for the polyphase resampler input buffer (I=3, D=4) and its `addrprocess` address generator. It gates ADC samples into the buffer through `ready` and launches FIR processing with `FirStart` once `ProcessStart` fires. It counts FIR outputs via `OutBufwea`, then runs the 21-tap history copy through `InCopy`/`InCopyEnd`. It owns the `addrprocess` reset and the `RisingTone` mode select, and updates both only at frame boundaries.

## Interface
- `COPY_LEN`, 21: history samples moved by the copy phase; informational, used only by the timeout check.
- `TAIL_LEN`, 9: samples written after `ProcessStart` before fill stalls (buffer addresses 780..788).
- `OUT_PER_FRAME`, 568: FIR output writes that complete one frame.
- `CNT_W`, 10: width of the output counter.
- `sys_clk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: run gate for sample acceptance and FIR launch.
- `restart` in 1: synchronous soft restart pulse.
- `tone_sel` in 1: requested `RisingTone` mode, latched per frame.
- `adc_valid` in 1: ADC sample available.
- `adc_ack` out 1: sample consumed; equal to `ready`.
- `ready` out 1: buffer write strobe to `addrprocess`.
- `ProcessStart` in 1: from `addrprocess`.
- `FirStart` out 1: FIR launch pulse.
- `OutBufwea` in 1: FIR output write strobe.
- `InCopy` out 1: history copy enable.
- `InCopyEnd` in 1: copy counter carry.
- `RisingTone` out 1: FIR mode select.
- `ap_reset` out 1: active-high synchronous reset to `addrprocess`.
- `state` out 2: current FSM state.
- `frame_cnt` out 16: completed frames, wraps at 0xFFFF→0.
- `seq_err` out 1: sticky sequencing error.

## Operation
- States: INIT=0, FILL=1, PROC=2, COPY=3.
- INIT: `ap_reset`=1. Always advances to FILL after one cycle.
- FILL: `ready` = `adc_valid & enable`. When `ProcessStart` is sampled high, go to PROC, pulse `FirStart` for exactly one cycle, and clear `tail_cnt` and `out_cnt`.
- PROC:
  - `ready` = `adc_valid & enable & (tail_cnt < TAIL_LEN)`. Each `ready` cycle increments `tail_cnt`.
  - Once `tail_cnt` reaches `TAIL_LEN`, `ready` stays 0 and the ADC is back-pressured.
  - Each `OutBufwea` increments `out_cnt`.
  - Exit to COPY when `out_cnt == OUT_PER_FRAME` and `tail_cnt == TAIL_LEN`.
- COPY: `InCopy`=1, `ready`=0. When `InCopyEnd` is sampled high:
  - go to FILL;
  - `InCopy` drops on the following cycle;
  - `frame_cnt` increments;
  - `RisingTone` takes `tone_sel`.
- `enable` low blocks `ready` and `FirStart`. A `ProcessStart` that arrives while `enable`=0 is held pending and launches when `enable` rises. PROC and COPY still complete normally.
- `restart` from any state goes to INIT and clears counters except `frame_cnt`. If `restart` coincides with any other transition, `restart` wins.
- `seq_err` is set by any of these, and is cleared only by `reset_n`:
  - `ProcessStart` outside FILL;
  - `OutBufwea` outside PROC;
  - `InCopyEnd` outside COPY;
  - COPY lasting more than `COPY_LEN`+4 cycles.
- Extra `OutBufwea` pulses in PROC after `out_cnt` saturates at `OUT_PER_FRAME` are ignored. They do not set `seq_err`.

## Timing
- Reset values: state=INIT, `ap_reset`=1, `frame_cnt`=0, `RisingTone`=0, `seq_err`=0; all other outputs 0.
- After `reset_n` deasserts, `ap_reset` stays 1 for one further cycle and FILL is entered on the second edge.
- `ready`/`adc_ack` are combinational from `adc_valid` and registered state. This gives zero-latency acknowledge; a sample transfers when `adc_valid & adc_ack` at an edge.
- `FirStart`, `InCopy`, `ap_reset`, `RisingTone` and `frame_cnt` are registered.
- `FirStart` is high in the cycle after `ProcessStart` is sampled.
- `InCopy` rises in the cycle after the PROC exit condition holds.
- `ready` is 0 in the same cycle as `FirStart`; the `tail_cnt` gating applies from the next cycle on.
- `RisingTone` never toggles while `InCopy`=1 or during PROC.

## Structure
- Package `inbuf_pkg` holds:
  - the state encoding (INIT/FILL/PROC/COPY);
  - defaults for `TAIL_LEN`, `OUT_PER_FRAME`, `COPY_LEN`;
  - the buffer constants 21, 779 and 788.
- Sub-module `tc_counter`: an enable/clear counter with terminal-count flag. Instantiate it three times: `tail_cnt` (4 bits), `out_cnt` (`CNT_W`), and the COPY timeout (5 bits).

## Test plan
- Reset: hold `reset_n` low 5 cycles, then release → `ap_reset`=1 for one cycle, state=FILL on cycle 2, all other outputs 0.
- Nominal frame: `adc_valid`=1 continuously, pulse `ProcessStart` after 758 acks → `FirStart` one cycle later; exactly 9 further acks, then `adc_ack`=0; after 568 `OutBufwea` pulses, `InCopy`=1; `InCopyEnd` at copy cycle 21 → FILL, `frame_cnt`=1.
- Mode latch: toggle `tone_sel` during PROC → `RisingTone` unchanged until the COPY→FILL edge, then equals `tone_sel`.
- Enable gating: `enable`=0 when `ProcessStart` arrives → no `FirStart`; raise `enable` 10 cycles later → `FirStart` on the next cycle.
- Restart collision: `restart` in the same cycle as `InCopyEnd` → INIT, `frame_cnt` not incremented, `ap_reset`=1 for one cycle.
- Errors: `OutBufwea` during FILL → `seq_err`=1 and it persists across `restart`. Withhold `InCopyEnd` → `seq_err` at COPY cycle 26.

Source files
------------

// File: rtl/inbuf_pkg.sv
// Shared constants for the polyphase resampler input-buffer sequencer:
// FSM encoding, frame geometry defaults and buffer address landmarks.
package inbuf_pkg;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_PROC = 2'd2;
  localparam logic [1:0] ST_COPY = 2'd3;

  // Buffer landmarks: 21-tap history, last pre-start address, last buffer address.
  localparam int BUF_HIST_LEN  = 21;
  localparam int BUF_PROC_ADDR = 779;
  localparam int BUF_LAST_ADDR = 788;

  localparam int COPY_LEN_DEF      = BUF_HIST_LEN;
  localparam int TAIL_LEN_DEF      = BUF_LAST_ADDR - BUF_PROC_ADDR;
  localparam int OUT_PER_FRAME_DEF = 568;
  localparam int CNT_W_DEF         = 10;

endpackage

// File: rtl/inbuf_sched_tc_counter.sv
// Enable/clear up-counter that holds at TERM and flags terminal count.
module tc_counter #(
  parameter int W    = 4,
  parameter int TERM = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [W-1:0] cnt;

  assign tc = (cnt == W'(TERM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && !tc)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/inbuf_sched.sv
// Frame sequencer for the resampler input buffer: fill, FIR processing,
// history copy, with per-frame mode latch and sticky sequencing error.
module inbuf_sched
  import inbuf_pkg::*;
#(
  parameter int COPY_LEN      = COPY_LEN_DEF,
  parameter int TAIL_LEN      = TAIL_LEN_DEF,
  parameter int OUT_PER_FRAME = OUT_PER_FRAME_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        restart,
  input  logic        tone_sel,
  input  logic        adc_valid,
  output logic        adc_ack,
  output logic        ready,
  input  logic        ProcessStart,
  output logic        FirStart,
  input  logic        OutBufwea,
  output logic        InCopy,
  input  logic        InCopyEnd,
  output logic        RisingTone,
  output logic        ap_reset,
  output logic [1:0]  state,
  output logic [15:0] frame_cnt,
  output logic        seq_err
);

  logic [1:0] state_d;
  logic       is_init, is_fill, is_proc, is_copy;
  logic       start_pend, launch, proc_done, copy_done;
  logic       tail_tc, out_tc, tmo_tc, tmo_hit, err_evt;

  assign is_init = (state == ST_INIT);
  assign is_fill = (state == ST_FILL);
  assign is_proc = (state == ST_PROC);
  assign is_copy = (state == ST_COPY);

  // A start seen while disabled is remembered until enable returns.
  assign launch    = is_fill & enable & (ProcessStart | start_pend);
  assign proc_done = is_proc & out_tc & tail_tc;
  assign copy_done = is_copy & InCopyEnd;

  assign ready   = adc_valid & enable &
                   (is_fill | (is_proc & ~FirStart & ~tail_tc));
  assign adc_ack = ready;

  assign tmo_hit = is_copy & tmo_tc & ~InCopyEnd & ~restart;
  assign err_evt = (ProcessStart & ~is_fill) | (OutBufwea & ~is_proc) |
                   (InCopyEnd & ~is_copy) | tmo_hit;

  tc_counter #(.W(4), .TERM(TAIL_LEN)) u_tail_cnt (
    .clk   (sys_clk),
    .rst_n (reset_n),
    .clr   (launch | restart),
    .en    (ready & is_proc),
    .tc    (tail_tc)
  );

  tc_counter #(.W(CNT_W), .TERM(OUT_PER_FRAME)) u_out_cnt (
    .clk   (sys_clk),
    .rst_n (reset_n),
    .clr   (launch | restart),
    .en    (OutBufwea & is_proc),
    .tc    (out_tc)
  );

  // Timeout flags on the last allowed COPY cycle (COPY_LEN+4 cycles total).
  tc_counter #(.W(5), .TERM(COPY_LEN + 3)) u_copy_tmo (
    .clk   (sys_clk),
    .rst_n (reset_n),
    .clr   (~is_copy | restart),
    .en    (is_copy),
    .tc    (tmo_tc)
  );

  always_comb begin
    state_d = state;
    if (is_init)
      state_d = ST_FILL;
    else if (launch)
      state_d = ST_PROC;
    else if (proc_done)
      state_d = ST_COPY;
    else if (copy_done)
      state_d = ST_FILL;
    if (restart)
      state_d = ST_INIT;
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_INIT;
      ap_reset   <= 1'b1;
      FirStart   <= 1'b0;
      InCopy     <= 1'b0;
      RisingTone <= 1'b0;
      frame_cnt  <= '0;
      seq_err    <= 1'b0;
      start_pend <= 1'b0;
    end else begin
      state    <= state_d;
      ap_reset <= (state_d == ST_INIT);
      FirStart <= launch & ~restart;
      InCopy   <= (state_d == ST_COPY);
      if (restart || launch)
        start_pend <= 1'b0;
      else if (is_fill && ProcessStart)
        start_pend <= 1'b1;
      if (copy_done && !restart) begin
        frame_cnt  <= frame_cnt + 16'd1;
        RisingTone <= tone_sel;
      end
      if (err_evt)
        seq_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inbuf_sched.sv
// Directed bench for inbuf_sched: reset, nominal frame, mode latch,
// enable gating, restart collision and error detection.
module tb_inbuf_sched;

  logic        sys_clk      = 1'b0;
  logic        reset_n      = 1'b0;
  logic        enable       = 1'b0;
  logic        restart      = 1'b0;
  logic        tone_sel     = 1'b0;
  logic        adc_valid    = 1'b0;
  logic        ProcessStart = 1'b0;
  logic        OutBufwea    = 1'b0;
  logic        InCopyEnd    = 1'b0;
  logic        adc_ack, ready, FirStart, InCopy, RisingTone, ap_reset, seq_err;
  logic [1:0]  state;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int acks;

  always #5 sys_clk = ~sys_clk;

  inbuf_sched dut (
    .sys_clk      (sys_clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .restart      (restart),
    .tone_sel     (tone_sel),
    .adc_valid    (adc_valid),
    .adc_ack      (adc_ack),
    .ready        (ready),
    .ProcessStart (ProcessStart),
    .FirStart     (FirStart),
    .OutBufwea    (OutBufwea),
    .InCopy       (InCopy),
    .InCopyEnd    (InCopyEnd),
    .RisingTone   (RisingTone),
    .ap_reset     (ap_reset),
    .state        (state),
    .frame_cnt    (frame_cnt),
    .seq_err      (seq_err)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    // Reset held 5 cycles
    repeat (5) cyc();
    chk("rst_state", int'(state), 0);
    chk("rst_ap_reset", int'(ap_reset), 1);
    chk("rst_outs", int'({FirStart, InCopy, RisingTone, seq_err, adc_ack, ready}), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    reset_n = 1'b1;
    #1;
    chk("rel_c1_state", int'(state), 0);
    chk("rel_c1_ap_reset", int'(ap_reset), 1);
    cyc();
    chk("rel_c2_state", int'(state), 1);
    chk("rel_c2_ap_reset", int'(ap_reset), 0);
    chk("rel_c2_outs", int'({FirStart, InCopy, RisingTone, seq_err, adc_ack}), 0);

    // Nominal frame
    enable    = 1'b1;
    adc_valid = 1'b1;
    #1;
    acks = 0;
    for (int i = 0; i < 1000 && acks < 758; i++) begin
      if (adc_ack) acks++;
      cyc();
    end
    chk("fill_acks", acks, 758);
    ProcessStart = 1'b1;
    #1;
    chk("start_cycle_ack", int'(adc_ack), 1);
    cyc();
    ProcessStart = 1'b0;
    #1;
    chk("firstart", int'(FirStart), 1);
    chk("proc_state", int'(state), 2);
    chk("firstart_ack", int'(adc_ack), 0);
    tone_sel = 1'b1;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 1) chk("firstart_pulse", int'(FirStart), 0);
      if (adc_ack) acks++;
      cyc();
    end
    chk("tail_acks", acks, 9);
    chk("tail_stall", int'(adc_ack), 0);
    chk("tone_hold_proc", int'(RisingTone), 0);
    OutBufwea = 1'b1;
    repeat (567) cyc();
    chk("out567_incopy", int'(InCopy), 0);
    chk("out567_state", int'(state), 2);
    cyc();
    chk("out568_incopy", int'(InCopy), 0);
    cyc();
    OutBufwea = 1'b0;
    #1;
    chk("copy_incopy", int'(InCopy), 1);
    chk("copy_state", int'(state), 3);
    chk("copy_ready", int'(adc_ack), 0);
    chk("extra_wea_no_err", int'(seq_err), 0);
    repeat (20) cyc();
    chk("tone_hold_copy", int'(RisingTone), 0);
    InCopyEnd = 1'b1;
    cyc();
    InCopyEnd = 1'b0;
    #1;
    chk("copyend_state", int'(state), 1);
    chk("copyend_incopy", int'(InCopy), 0);
    chk("copyend_frame", int'(frame_cnt), 1);
    chk("copyend_tone", int'(RisingTone), 1);
    chk("frame1_err", int'(seq_err), 0);

    // Enable gating with a pending start
    enable       = 1'b0;
    ProcessStart = 1'b1;
    #1;
    chk("dis_ack", int'(adc_ack), 0);
    cyc();
    ProcessStart = 1'b0;
    chk("dis_no_fir", int'(FirStart), 0);
    repeat (9) cyc();
    chk("dis_still_fill", int'(state), 1);
    chk("dis_still_nofir", int'(FirStart), 0);
    enable = 1'b1;
    cyc();
    chk("en_fir", int'(FirStart), 1);
    chk("en_state", int'(state), 2);

    // Restart colliding with InCopyEnd
    OutBufwea = 1'b1;
    repeat (568) cyc();
    OutBufwea = 1'b0;
    cyc();
    chk("f2_copy_state", int'(state), 3);
    tone_sel = 1'b0;
    repeat (5) cyc();
    restart   = 1'b1;
    InCopyEnd = 1'b1;
    cyc();
    restart   = 1'b0;
    InCopyEnd = 1'b0;
    chk("rc_state", int'(state), 0);
    chk("rc_ap_reset", int'(ap_reset), 1);
    chk("rc_frame", int'(frame_cnt), 1);
    chk("rc_tone", int'(RisingTone), 1);
    chk("rc_incopy", int'(InCopy), 0);
    cyc();
    chk("rc_fill", int'(state), 1);
    chk("rc_ap_reset_off", int'(ap_reset), 0);
    chk("rc_err", int'(seq_err), 0);

    // OutBufwea in FILL is an error that survives restart
    OutBufwea = 1'b1;
    cyc();
    OutBufwea = 1'b0;
    chk("wea_fill_err", int'(seq_err), 1);
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    chk("err_restart_state", int'(state), 0);
    chk("err_sticky", int'(seq_err), 1);

    // COPY timeout after a fresh reset
    reset_n = 1'b0;
    repeat (2) cyc();
    chk("rst2_err", int'(seq_err), 0);
    chk("rst2_frame", int'(frame_cnt), 0);
    reset_n = 1'b1;
    cyc();
    ProcessStart = 1'b1;
    cyc();
    ProcessStart = 1'b0;
    chk("to_fir", int'(FirStart), 1);
    OutBufwea = 1'b1;
    repeat (568) cyc();
    OutBufwea = 1'b0;
    cyc();
    chk("to_copy", int'(state), 3);
    repeat (24) cyc();
    chk("to_c25", int'(seq_err), 0);
    cyc();
    chk("to_c26", int'(seq_err), 1);
    chk("to_c26_state", int'(state), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
